// File: rtl/micro_seq_pkg.sv
// -----------------------------------------------------------------------------
// micro_seq_pkg
// Shared definitions for the microprogram sequencer:
//   - ty_e    : sequencing type held in every microword
//   - state_e : sequencer FSM states
//   - helper functions giving the bit layout of a stored microword
//     {CW, TY[2:0], CSEL, POL, NA}, NA in the least significant bits.
// No ports (package).
// -----------------------------------------------------------------------------
package micro_seq_pkg;

    localparam int TY_WIDTH = 3;

    typedef enum logic [TY_WIDTH-1:0] {
        TY_NEXT        = 3'd0,
        TY_JUMP        = 3'd1,
        TY_BRANCH      = 3'd2,
        TY_DISPATCH_IB = 3'd3,
        TY_DISPATCH_SB = 3'd4,
        TY_CALL        = 3'd5,
        TY_RETURN      = 3'd6,
        TY_HALT        = 3'd7
    } ty_e;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_INST = 2'd2,
        ST_FAULT     = 2'd3
    } state_e;

    // A single flag still needs a one-bit select field.
    function automatic int csel_width(input int flag_count);
        return (flag_count > 1) ? $clog2(flag_count) : 1;
    endfunction

    function automatic int mw_width(input int cw_w, input int addr_w, input int csel_w);
        return cw_w + TY_WIDTH + csel_w + 1 + addr_w;
    endfunction

    function automatic int pol_bit(input int addr_w);
        return addr_w;
    endfunction

    function automatic int csel_lsb(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int ty_lsb(input int addr_w, input int csel_w);
        return addr_w + 1 + csel_w;
    endfunction

    function automatic int cw_lsb(input int addr_w, input int csel_w);
        return addr_w + 1 + csel_w + TY_WIDTH;
    endfunction

endpackage

// File: rtl/micro_return_stack.sv
// -----------------------------------------------------------------------------
// micro_return_stack
// LIFO of micro return addresses used by CALL/RETURN.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears level only)
//   push_i         : store push_data_i on top (ignored when full)
//   pop_i          : discard the top entry (ignored when empty)
//   push_data_i    : return address to push
//   top_data_o     : current top entry (valid when !empty_o)
//   full_o/empty_o : occupancy flags
//   level_o        : number of entries held
// -----------------------------------------------------------------------------
module micro_return_stack #(
    parameter  int DEPTH  = 4,
    parameter  int AW     = 6,
    localparam int LVL_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [AW-1:0]    push_data_i,
    output logic [AW-1:0]    top_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [LVL_W-1:0]          level_q, level_d;
    logic [DEPTH-1:0][AW-1:0]  entries_w;
    logic [IDX_W-1:0]          top_idx;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // The sequencer never pushes and pops in the same cycle; push wins if it did.
    always_comb begin
        level_d = level_q;
        if (push_i && !full_o) begin
            level_d = level_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Entry storage needs no reset: only entries below level_q are ever read.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AW-1:0] entry_q;

        always_ff @(posedge clk_i) begin
            if (push_i && !full_o && (level_q == LVL_W'(gi))) begin
                entry_q <= push_data_i;
            end
        end

        assign entries_w[gi] = entry_q;
    end

    assign top_idx    = IDX_W'(level_q - 1'b1);
    assign top_data_o = entries_w[top_idx];

endmodule

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
// Microprogram sequencer with a writable control store. Each stored word
// carries a control word for the execution unit plus sequencing fields
// {TY, CSEL, POL, NA} that select the next micro-address.
// Ports:
//   PLClock, PLResetN          : clock, asynchronous active-low reset
//   LoadEn/LoadAddr/LoadData   : control-store write port (usable any time)
//   InstValid/InstAccept       : decoder handshake for dispatch words
//   IbAddress/SbAddress        : dispatch targets from the decoder
//   ConditionFlag              : EU flags tested by BRANCH
//   EuStall                    : EU cannot take the presented word
//   ControlWord/ControlValid   : word to execute (zero when not valid)
//   MicroPc                    : address of the presented word
//   StackLevel/Fault           : return-stack depth, sticky stack fault
// -----------------------------------------------------------------------------
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter  int CW_WIDTH    = 26,
    parameter  int ADDR_WIDTH  = 6,
    parameter  int FLAG_COUNT  = 4,
    parameter  int STACK_DEPTH = 4,
    parameter  int RESET_ADDR  = 0,
    localparam int CSEL_W      = csel_width(FLAG_COUNT),
    localparam int MW_WIDTH    = mw_width(CW_WIDTH, ADDR_WIDTH, CSEL_W),
    localparam int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  PLClock,
    input  logic                  PLResetN,
    input  logic                  LoadEn,
    input  logic [ADDR_WIDTH-1:0] LoadAddr,
    input  logic [MW_WIDTH-1:0]   LoadData,
    input  logic                  InstValid,
    output logic                  InstAccept,
    input  logic [ADDR_WIDTH-1:0] IbAddress,
    input  logic [ADDR_WIDTH-1:0] SbAddress,
    input  logic [FLAG_COUNT-1:0] ConditionFlag,
    input  logic                  EuStall,
    output logic [CW_WIDTH-1:0]   ControlWord,
    output logic                  ControlValid,
    output logic [ADDR_WIDTH-1:0] MicroPc,
    output logic [LVL_W-1:0]      StackLevel,
    output logic                  Fault
);

    localparam int STORE_DEPTH = 2 ** ADDR_WIDTH;
    localparam int POL_BIT     = pol_bit(ADDR_WIDTH);
    localparam int CSEL_LSB    = csel_lsb(ADDR_WIDTH);
    localparam int TY_LSB      = ty_lsb(ADDR_WIDTH, CSEL_W);
    localparam int CW_LSB      = cw_lsb(ADDR_WIDTH, CSEL_W);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mpc_q, mpc_d;
    logic                  halt_q, halt_d;

    logic [MW_WIDTH-1:0]   store_mem [STORE_DEPTH];
    logic [MW_WIDTH-1:0]   word_q;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Decoded fields of the presented word
    ty_e                   word_ty;
    logic [CSEL_W-1:0]     word_csel;
    logic                  word_pol;
    logic [ADDR_WIDTH-1:0] word_na;
    logic [ADDR_WIDTH-1:0] mpc_plus1;
    logic [ADDR_WIDTH-1:0] dispatch_addr;
    logic                  branch_taken;
    logic                  inst_accept;

    logic                  stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic [LVL_W-1:0]      stk_level;

    assign word_ty       = ty_e'(word_q[TY_LSB +: TY_WIDTH]);
    assign word_csel     = word_q[CSEL_LSB +: CSEL_W];
    assign word_pol      = word_q[POL_BIT];
    assign word_na       = word_q[ADDR_WIDTH-1:0];
    assign mpc_plus1     = mpc_q + 1'b1;
    assign dispatch_addr = (word_ty == TY_DISPATCH_SB) ? SbAddress : IbAddress;
    assign branch_taken  = ConditionFlag[word_csel] ^ word_pol;

    micro_return_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_return_stack (
        .clk_i       (PLClock),
        .rst_ni      (PLResetN),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (mpc_plus1),
        .top_data_o  (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty),
        .level_o     (stk_level)
    );

    // Next-state / next-address. Whenever rd_en is set, rd_addr becomes the
    // new MicroPc and its word is read into word_q at the same edge, so
    // straight-line sequencing runs at one word per cycle.
    always_comb begin
        state_d     = state_q;
        mpc_d       = mpc_q;
        halt_d      = halt_q;
        rd_en       = 1'b0;
        rd_addr     = mpc_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        inst_accept = 1'b0;

        case (state_q)
            ST_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = RESET_PC;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (!halt_q && !EuStall) begin
                    rd_en = 1'b1;
                    case (word_ty)
                        TY_NEXT:   rd_addr = mpc_plus1;
                        TY_JUMP:   rd_addr = word_na;
                        TY_BRANCH: rd_addr = branch_taken ? word_na : mpc_plus1;
                        TY_DISPATCH_IB, TY_DISPATCH_SB: begin
                            if (InstValid) begin
                                inst_accept = 1'b1;
                                rd_addr     = dispatch_addr;
                            end else begin
                                rd_en   = 1'b0;
                                state_d = ST_WAIT_INST;
                            end
                        end
                        TY_CALL: begin
                            if (stk_full) begin
                                rd_en   = 1'b0;
                                state_d = ST_FAULT;
                            end else begin
                                stk_push = 1'b1;
                                rd_addr  = word_na;
                            end
                        end
                        TY_RETURN: begin
                            if (stk_empty) begin
                                rd_en   = 1'b0;
                                state_d = ST_FAULT;
                            end else begin
                                stk_pop = 1'b1;
                                rd_addr = stk_top;
                            end
                        end
                        default: begin
                            // HALT: keep the word and MicroPc, stop presenting
                            rd_en  = 1'b0;
                            halt_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_WAIT_INST: begin
                // word_q still holds the dispatch word, so its TY picks IB/SB
                if (InstValid) begin
                    inst_accept = 1'b1;
                    rd_en       = 1'b1;
                    rd_addr     = dispatch_addr;
                    state_d     = ST_RUN;
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rd_en) begin
            mpc_d = rd_addr;
        end
    end

    always_ff @(posedge PLClock or negedge PLResetN) begin
        if (!PLResetN) begin
            state_q <= ST_FETCH;
            mpc_q   <= RESET_PC;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            halt_q  <= halt_d;
        end
    end

    // Control store with a registered read port. Write and read share one
    // process, so a read of the address being written returns the old word.
    always_ff @(posedge PLClock) begin
        if (LoadEn) begin
            store_mem[LoadAddr] <= LoadData;
        end
        if (rd_en) begin
            word_q <= store_mem[rd_addr];
        end
    end

    assign ControlValid = (state_q == ST_RUN) && !halt_q;
    assign ControlWord  = ControlValid ? word_q[CW_LSB +: CW_WIDTH] : '0;
    assign MicroPc      = mpc_q;
    assign StackLevel   = stk_level;
    assign Fault        = (state_q == ST_FAULT);
    assign InstAccept   = inst_accept;

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
// Drives directed and random microprograms into micro_sequencer and compares
// every output each cycle against a behavioural model of the sequencing
// rules (program counter, return-address queue, run mode).
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

    localparam int CW     = 26;
    localparam int AW     = 6;
    localparam int FC     = 4;
    localparam int SD     = 4;
    localparam int CSW    = 2;
    localparam int MW     = CW + 3 + CSW + 1 + AW;
    localparam int NWORDS = 64;
    localparam int RST_ADDR = 0;

    localparam int T_NEXT = 0, T_JUMP = 1, T_BRANCH = 2, T_DIB = 3;
    localparam int T_DSB  = 4, T_CALL = 5, T_RET = 6, T_HALT = 7;

    logic          PLClock = 1'b0;
    logic          PLResetN = 1'b0;
    logic          LoadEn = 1'b0;
    logic [AW-1:0] LoadAddr = '0;
    logic [MW-1:0] LoadData = '0;
    logic          InstValid = 1'b0;
    logic          InstAccept;
    logic [AW-1:0] IbAddress = '0;
    logic [AW-1:0] SbAddress = '0;
    logic [FC-1:0] ConditionFlag = '0;
    logic          EuStall = 1'b0;
    logic [CW-1:0] ControlWord;
    logic          ControlValid;
    logic [AW-1:0] MicroPc;
    logic [2:0]    StackLevel;
    logic          Fault;

    micro_sequencer dut (
        .PLClock       (PLClock),
        .PLResetN      (PLResetN),
        .LoadEn        (LoadEn),
        .LoadAddr      (LoadAddr),
        .LoadData      (LoadData),
        .InstValid     (InstValid),
        .InstAccept    (InstAccept),
        .IbAddress     (IbAddress),
        .SbAddress     (SbAddress),
        .ConditionFlag (ConditionFlag),
        .EuStall       (EuStall),
        .ControlWord   (ControlWord),
        .ControlValid  (ControlValid),
        .MicroPc       (MicroPc),
        .StackLevel    (StackLevel),
        .Fault         (Fault)
    );

    always #5 PLClock = ~PLClock;

    // ---------------- behavioural model ----------------
    typedef struct {
        int cw;
        int ty;
        int csel;
        int pol;
        int na;
    } uword_t;

    typedef enum {M_FETCH, M_RUN, M_WAIT, M_HALT, M_FAULT} mmode_e;

    uword_t m_store [NWORDS];
    uword_t m_word;
    uword_t wr_word;
    mmode_e m_mode;
    int     m_pc;
    int     m_stack [$];

    int n_checks = 0;
    int n_errors = 0;

    // episode knobs
    int ep_stall_pct, ep_iv_pct, ep_wr_pct, ep_flags, ep_iv_from;
    int ep_ib, ep_sb, ep_stall_from, ep_stall_to, ep_rst_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic uword_t mk(input int ty, input int na, input int csel = 0, input int pol = 0);
        uword_t w;
        w.cw   = int'($urandom_range(32'h3FF_FFFF));
        w.ty   = ty;
        w.csel = csel;
        w.pol  = pol;
        w.na   = na;
        return w;
    endfunction

    function automatic uword_t random_word();
        int r = int'($urandom_range(99));
        int ty;
        if      (r < 30) ty = T_NEXT;
        else if (r < 45) ty = T_JUMP;
        else if (r < 62) ty = T_BRANCH;
        else if (r < 68) ty = T_DIB;
        else if (r < 74) ty = T_DSB;
        else if (r < 84) ty = T_CALL;
        else if (r < 95) ty = T_RET;
        else             ty = T_HALT;
        return mk(ty, int'($urandom_range(NWORDS - 1)), int'($urandom_range(3)), int'($urandom_range(1)));
    endfunction

    function automatic logic [MW-1:0] pack_word(input uword_t w);
        logic [CW-1:0]  cw   = CW'(w.cw);
        logic [2:0]     ty   = 3'(w.ty);
        logic [CSW-1:0] csel = CSW'(w.csel);
        logic           pol  = 1'(w.pol);
        logic [AW-1:0]  na   = AW'(w.na);
        return {cw, ty, csel, pol, na};
    endfunction

    task automatic model_reset();
        m_mode = M_FETCH;
        m_pc   = RST_ADDR;
        m_stack.delete();
    endtask

    task automatic m_goto(input int a);
        m_pc   = a % NWORDS;
        m_word = m_store[m_pc];
        m_mode = M_RUN;
    endtask

    // One rising edge of the model, using the inputs currently driven.
    task automatic model_edge();
        int nxt = (m_pc + 1) % NWORDS;
        int tgt;
        case (m_mode)
            M_FETCH: m_goto(RST_ADDR);
            M_RUN: if (!EuStall) begin
                case (m_word.ty)
                    T_NEXT:   m_goto(nxt);
                    T_JUMP:   m_goto(m_word.na);
                    T_BRANCH: m_goto((int'(ConditionFlag[m_word.csel]) != m_word.pol) ? m_word.na : nxt);
                    T_DIB, T_DSB: begin
                        if (InstValid) begin
                            tgt = (m_word.ty == T_DIB) ? int'(IbAddress) : int'(SbAddress);
                            m_goto(tgt);
                        end else begin
                            m_mode = M_WAIT;
                        end
                    end
                    T_CALL: begin
                        if (m_stack.size() == SD) begin
                            m_mode = M_FAULT;
                        end else begin
                            m_stack.push_back(nxt);
                            m_goto(m_word.na);
                        end
                    end
                    T_RET: begin
                        if (m_stack.size() == 0) m_mode = M_FAULT;
                        else                     m_goto(m_stack.pop_back());
                    end
                    default: m_mode = M_HALT;
                endcase
            end
            M_WAIT: if (InstValid) begin
                tgt = (m_word.ty == T_DIB) ? int'(IbAddress) : int'(SbAddress);
                m_goto(tgt);
            end
            default: ;
        endcase
        // store update lands after the read: same-address fetch sees old data
        if (LoadEn) m_store[LoadAddr] = wr_word;
    endtask

    task automatic check_outputs();
        logic exp_cv  = (m_mode == M_RUN);
        logic is_disp = (m_word.ty == T_DIB) || (m_word.ty == T_DSB);
        logic exp_acc = ((m_mode == M_RUN) && !EuStall && is_disp && InstValid) ||
                        ((m_mode == M_WAIT) && InstValid);
        check_eq("ControlValid", 64'(ControlValid), 64'(exp_cv));
        check_eq("ControlWord", 64'(ControlWord), exp_cv ? 64'(m_word.cw) : 64'd0);
        check_eq("MicroPc", 64'(MicroPc), 64'(m_pc));
        check_eq("StackLevel", 64'(StackLevel), 64'(m_stack.size()));
        check_eq("Fault", 64'(Fault), 64'(m_mode == M_FAULT));
        check_eq("InstAccept", 64'(InstAccept), 64'(exp_acc));
    endtask

    task automatic check_reset_values();
        check_eq("rst_ControlValid", 64'(ControlValid), 64'd0);
        check_eq("rst_ControlWord", 64'(ControlWord), 64'd0);
        check_eq("rst_InstAccept", 64'(InstAccept), 64'd0);
        check_eq("rst_MicroPc", 64'(MicroPc), 64'(RST_ADDR));
        check_eq("rst_StackLevel", 64'(StackLevel), 64'd0);
        check_eq("rst_Fault", 64'(Fault), 64'd0);
    endtask

    task automatic default_knobs();
        ep_stall_pct = 0; ep_iv_pct = 0; ep_wr_pct = 0; ep_flags = -1;
        ep_iv_from = -1; ep_ib = -1; ep_sb = -1;
        ep_stall_from = -1; ep_stall_to = -2; ep_rst_cyc = -1;
    endtask

    task automatic fill_halt();
        for (int a = 0; a < NWORDS; a++) m_store[a] = mk(T_HALT, 0);
    endtask

    // Called at posedge+1. Asserts reset (checked asynchronously), loads the
    // whole store under reset, then releases reset.
    task automatic load_and_reset();
        InstValid = 1'b1;
        PLResetN  = 1'b0;
        #1;
        check_reset_values();
        for (int a = 0; a < NWORDS; a++) begin
            LoadEn   = 1'b1;
            LoadAddr = AW'(a);
            LoadData = pack_word(m_store[a]);
            @(posedge PLClock); #1;
        end
        LoadEn    = 1'b0;
        InstValid = 1'b0;
        model_reset();
        PLResetN  = 1'b1;
    endtask

    task automatic run_cycle(input int cyc);
        EuStall = ((cyc >= ep_stall_from) && (cyc <= ep_stall_to)) ||
                  (int'($urandom_range(99)) < ep_stall_pct);
        InstValid = ((ep_iv_from >= 0) && (cyc >= ep_iv_from)) ||
                    (int'($urandom_range(99)) < ep_iv_pct);
        IbAddress = (ep_ib >= 0) ? AW'(ep_ib) : AW'($urandom);
        SbAddress = (ep_sb >= 0) ? AW'(ep_sb) : AW'($urandom);
        ConditionFlag = (ep_flags >= 0) ? FC'(ep_flags) : FC'($urandom);
        LoadEn = (int'($urandom_range(99)) < ep_wr_pct);
        if (LoadEn) begin
            wr_word  = random_word();
            LoadAddr = ($urandom_range(1) == 0) ? AW'(m_pc + 1) : AW'($urandom);
            LoadData = pack_word(wr_word);
        end
        #3;
        check_outputs();
        if (cyc == ep_rst_cyc) begin
            LoadEn   = 1'b0;
            PLResetN = 1'b0;
            #1;
            check_reset_values();
            model_reset();
            @(posedge PLClock); #1;
            PLResetN = 1'b1;
            return;
        end
        model_edge();
        @(posedge PLClock); #1;
    endtask

    task automatic run_episode(input int ncyc);
        load_and_reset();
        for (int c = 0; c < ncyc; c++) run_cycle(c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge PLClock); #1;

        // NEXT x3 then JUMP 0
        default_knobs(); fill_halt();
        m_store[0] = mk(T_NEXT, 0); m_store[1] = mk(T_NEXT, 0);
        m_store[2] = mk(T_NEXT, 0); m_store[3] = mk(T_JUMP, 0);
        run_episode(14);

        // BRANCH polarity with flag[2]=1
        default_knobs(); fill_halt(); ep_flags = 4'b0100;
        m_store[0]    = mk(T_BRANCH, 6'h10, 2, 0);
        m_store[6'h10] = mk(T_BRANCH, 6'h20, 2, 1);
        m_store[6'h11] = mk(T_JUMP, 0);
        run_episode(12);

        // DISPATCH_IB after 3 idle cycles, then zero-bubble DISPATCH_SB
        default_knobs(); fill_halt(); ep_iv_from = 4; ep_ib = 6'h15; ep_sb = 6'h30;
        m_store[0]     = mk(T_DIB, 0);
        m_store[6'h15] = mk(T_NEXT, 0);
        m_store[6'h16] = mk(T_DSB, 0);
        run_episode(12);

        // four nested calls and returns
        default_knobs(); fill_halt();
        m_store[0]     = mk(T_CALL, 6'h08);
        m_store[6'h08] = mk(T_CALL, 6'h10);
        m_store[6'h10] = mk(T_CALL, 6'h18);
        m_store[6'h18] = mk(T_CALL, 6'h20);
        m_store[6'h20] = mk(T_RET, 0);
        m_store[6'h19] = mk(T_RET, 0);
        m_store[6'h11] = mk(T_RET, 0);
        m_store[6'h09] = mk(T_RET, 0);
        run_episode(14);

        // fifth call overflows
        default_knobs(); fill_halt();
        for (int i = 0; i < 5; i++) m_store[i * 8] = mk(T_CALL, (i + 1) * 8);
        run_episode(10);

        // return on empty stack
        default_knobs(); fill_halt();
        m_store[0] = mk(T_RET, 0);
        run_episode(6);

        // EuStall for two cycles on a CALL word
        default_knobs(); fill_halt(); ep_stall_from = 1; ep_stall_to = 2;
        m_store[0]     = mk(T_CALL, 6'h08);
        m_store[6'h08] = mk(T_RET, 0);
        m_store[1]     = mk(T_JUMP, 0);
        run_episode(10);

        // reset while waiting for the decoder, then restart
        default_knobs(); fill_halt(); ep_rst_cyc = 3; ep_iv_from = 7; ep_sb = 6'h2A;
        m_store[0]     = mk(T_DSB, 0);
        m_store[6'h2A] = mk(T_NEXT, 0);
        m_store[6'h2B] = mk(T_JUMP, 6'h2A);
        run_episode(14);

        // random programs with random handshake, stalls, flags and writes
        for (int ep = 0; ep < 24; ep++) begin
            default_knobs();
            ep_stall_pct = 20; ep_iv_pct = 50; ep_wr_pct = 10;
            if (ep % 4 == 3) ep_rst_cyc = int'($urandom_range(10, 60));
            for (int a = 0; a < NWORDS; a++) m_store[a] = random_word();
            run_episode(80);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
